// File: rtl/cond_delay_and_n_pkg.sv
// Shared types and helpers for the conditional-delay AND cell.
package cond_delay_pkg;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    localparam int unsigned DEF_DW = 4;

    function automatic int unsigned num_pairs(int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned pair_of(int unsigned i);
        return i / 2;
    endfunction

endpackage

// File: rtl/cond_delay_and_n_sel.sv
// Delay selection: finds the lowest changed input, then picks the fast or slow
// delay of its pair by comparing the pair's bits against the condition pattern.
module cond_delay_sel
    import cond_delay_pkg::*;
#(
    parameter int unsigned               N          = 4,
    parameter int unsigned               DW         = DEF_DW,
    parameter logic [N-1:0]              COND_PAT   = 4'b0111,
    parameter logic [(N/2)*DW-1:0]       D_FAST_VEC = {4'd11, 4'd9},
    parameter logic [(N/2)*DW-1:0]       D_SLOW_VEC = {4'd13, 4'd13}
) (
    input  logic [N-1:0]  in,
    input  logic [N-1:0]  in_q,
    output logic          trig,
    output logic [DW-1:0] delay
);

    logic [N-1:0] change;
    logic [1:0]   pair_in;
    logic [1:0]   pair_pat;
    int unsigned  idx;
    int unsigned  k;

    always_comb begin
        change = in ^ in_q;
        trig   = |change;
        idx    = 0;
        // Descending scan so the lowest set index wins.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (change[i]) idx = i;
        end
        k        = pair_of(idx);
        pair_in  = in[2*k +: 2];
        pair_pat = COND_PAT[2*k +: 2];
        delay    = (pair_in == pair_pat) ? D_FAST_VEC[k*DW +: DW] : D_SLOW_VEC[k*DW +: DW];
    end

endmodule

// File: rtl/cond_delay_and_n.sv
// N-input AND with per-trigger conditional inertial delay on the registered output.
// Define COND_DELAY_STATS_EN to build the saturating cancelled-transition counter.
module cond_delay_and_n
    import cond_delay_pkg::*;
#(
    parameter int unsigned               N          = 4,
    parameter int unsigned               DW         = DEF_DW,
    parameter logic [N-1:0]              COND_PAT   = 4'b0111,
    parameter logic [(N/2)*DW-1:0]       D_FAST_VEC = {4'd11, 4'd9},
    parameter logic [(N/2)*DW-1:0]       D_SLOW_VEC = {4'd13, 4'd13}
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  in,
    output logic          out,
    output logic          pending,
    output logic [DW-1:0] cur_delay,
    output logic [15:0]   cancel_cnt
);

    localparam int unsigned NP = num_pairs(N);

    state_e        state_q;
    logic [N-1:0]  in_q;
    logic [DW-1:0] cnt_q;
    logic          pend_val_q;
    logic          new_and;
    logic          trig;
    logic [DW-1:0] sel_delay;
    logic          cancel_evt;

    cond_delay_sel #(
        .N          (N),
        .DW         (DW),
        .COND_PAT   (COND_PAT),
        .D_FAST_VEC (D_FAST_VEC),
        .D_SLOW_VEC (D_SLOW_VEC)
    ) u_sel (
        .in    (in),
        .in_q  (in_q),
        .trig  (trig),
        .delay (sel_delay)
    );

    assign new_and    = &in;
    assign pending    = (state_q == StWait);
    // Input returning to the current output level kills the scheduled edge.
    assign cancel_evt = (state_q == StWait) && en && (new_and == out);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            in_q       <= '0;
            cnt_q      <= '0;
            pend_val_q <= 1'b0;
            cur_delay  <= '0;
            out        <= 1'b0;
        end else begin
            if (en) in_q <= in;
            unique case (state_q)
                StIdle: begin
                    if (en && trig && (new_and != out)) begin
                        pend_val_q <= new_and;
                        cnt_q      <= sel_delay - DW'(1);
                        cur_delay  <= sel_delay;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (cancel_evt) begin
                        state_q <= StIdle;
                    end else if (cnt_q == '0) begin
                        out     <= pend_val_q;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - DW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef COND_DELAY_STATS_EN
    logic [15:0] cancel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cancel_q <= '0;
        end else if (cancel_evt && (cancel_q != 16'hFFFF)) begin
            cancel_q <= cancel_q + 16'd1;
        end
    end

    assign cancel_cnt = cancel_q;
`else
    assign cancel_cnt = '0;
`endif

    // Zero delays would underflow the countdown.
    for (genvar k = 0; k < NP; k++) begin : g_delay_chk
        a_delay_nonzero : assert property (@(posedge clk)
            (D_FAST_VEC[k*DW +: DW] != '0) && (D_SLOW_VEC[k*DW +: DW] != '0))
            else $error("cond_delay_and_n: zero delay configured for pair %0d", k);
    end

endmodule

// File: tb/tb_cond_delay_and_n.sv
// Scoreboard bench for cond_delay_and_n: output edges are predicted with their cycle.
module tb_cond_delay_and_n;

    typedef struct {
        int   cyc;
        logic val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  in;
    logic        out;
    logic        pending;
    logic [3:0]  cur_delay;
    logic [15:0] cancel_cnt;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    logic mon_en = 1'b0;
    logic prev_out = 1'b0;
    exp_t mon_e;

`ifdef COND_DELAY_STATS_EN
    localparam int EXP_CANCEL = 1;
`else
    localparam int EXP_CANCEL = 0;
`endif

    cond_delay_and_n dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in         (in),
        .out        (out),
        .pending    (pending),
        .cur_delay  (cur_delay),
        .cancel_cnt (cancel_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_edge(input int at, input logic v);
        exp_t e;
        e.cyc = at;
        e.val = v;
        sbq.push_back(e);
    endtask

    // Drive v, sampled at edge t; out must reach val at edge t+d.
    task automatic run_change(input logic [3:0] v, input int d, input logic val);
        in = v;
        tick();
        expect_edge(cyc + d, val);
        check("cur_delay", cur_delay, d);
        check("pending_start", pending, 1);
        for (int j = 1; j < d; j++) begin
            tick();
            check("pending_hold", pending, 1);
        end
        tick();
        check("pending_done", pending, 0);
        check("out_done", out, val);
    endtask

    // Every output edge must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && (out !== prev_out)) begin
            if (sbq.size() == 0) begin
                check("out_unexpected", out, prev_out);
            end else begin
                mon_e = sbq.pop_front();
                check("out_val", out, mon_e.val);
                check("out_cycle", cyc, mon_e.cyc);
            end
            prev_out = out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        in    = 4'hF;
        repeat (3) begin
            tick();
            check("rst_out", out, 0);
            check("rst_pending", pending, 0);
            check("rst_cur_delay", cur_delay, 0);
            check("rst_cancel", cancel_cnt, 0);
        end
        @(negedge clk);
        in       = 4'h0;
        en       = 1'b1;
        rst_n    = 1'b1;
        prev_out = out;
        mon_en   = 1'b1;
        repeat (2) tick();
        check("idle_pending", pending, 0);

        run_change(4'hF, 9, 1'b1);   // pair0 11 matches -> fast 9
        run_change(4'h7, 11, 1'b0);  // in[3], pair1 01 matches -> fast 11
        run_change(4'hF, 13, 1'b1);  // in[3], pair1 11 mismatches -> slow 13
        run_change(4'hB, 13, 1'b0);  // in[2], pair1 10 mismatches -> slow 13
        run_change(4'hF, 13, 1'b1);

        // Inertial cancel: 4-cycle glitch on in[0] against a 13-cycle delay.
        in = 4'hE;
        tick();
        check("glitch_delay", cur_delay, 13);
        check("glitch_pending", pending, 1);
        repeat (3) tick();
        in = 4'hF;
        tick();
        check("cancel_pending", pending, 0);
        check("cancel_out", out, 1);
        check("cancel_cnt", cancel_cnt, EXP_CANCEL);

        // en low mid-countdown: the scheduled fall still lands, the restore is not seen.
        in = 4'hE;
        tick();
        expect_edge(cyc + 13, 1'b0);
        check("en0_delay", cur_delay, 13);
        repeat (2) tick();
        en = 1'b0;
        in = 4'hF;
        repeat (11) tick();
        check("en0_out", out, 0);
        check("en0_pending", pending, 0);
        check("en0_cancel", cancel_cnt, EXP_CANCEL);
        en = 1'b1;
        tick();
        expect_edge(cyc + 9, 1'b1);
        check("en1_delay", cur_delay, 9);
        repeat (9) tick();
        check("en1_out", out, 1);

        run_change(4'hB, 13, 1'b0);
        in = 4'hE;
        repeat (2) tick();
        check("and0_pending", pending, 0);

        // Reset in the middle of a 9-cycle rise discards it.
        in = 4'hF;
        tick();
        check("rw_delay", cur_delay, 9);
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_out", out, 0);
        check("rw_pending", pending, 0);
        check("rw_cur_delay", cur_delay, 0);
        check("rw_cancel", cancel_cnt, 0);
        in = 4'h0;
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) tick();
        check("post_rst_out", out, 0);
        check("post_rst_pending", pending, 0);

        check("sb_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
